// File: rtl/seq_det_pkg.sv
// Shared types and constants for the letter-sequence detector front end.
// Symbol codes, feed FSM states and hit_mask bit positions live here.
package seq_det_pkg;

    localparam logic [1:0] SYM_L     = 2'b00;
    localparam logic [1:0] SYM_O     = 2'b01;
    localparam logic [1:0] SYM_V     = 2'b10;
    localparam logic [1:0] SYM_OTHER = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StFetch,
        StDrive,
        StSample
    } feed_state_t;

    // hit_mask layout: {volvo, vool, lol, oolvo}
    localparam int unsigned HIT_VOLVO = 3;
    localparam int unsigned HIT_VOOL  = 2;
    localparam int unsigned HIT_LOL   = 1;
    localparam int unsigned HIT_OOLVO = 0;

    // Returns {other, v, o, l}
    function automatic logic [3:0] sym_onehot(input logic [1:0] sym);
        logic [3:0] oh;
        case (sym)
            SYM_L:   oh = 4'b0001;
            SYM_O:   oh = 4'b0010;
            SYM_V:   oh = 4'b0100;
            default: oh = 4'b1000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seq_det_rr_arb.sv
// Two-way round-robin grant. The pointer source wins ties; the pointer moves
// to the other source when the current owner's burst completes.
module seq_det_rr_arb (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       done_i,
    input  logic       done_src_i,
    output logic       gnt_valid_o,
    output logic       gnt_src_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_src_o   = req_i[ptr_q] ? ptr_q : ~ptr_q;
        ptr_d       = ptr_q;
        if (done_i) begin
            ptr_d = ~done_src_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/seq_det_feed_ctrl.sv
// Feed controller: grants one source per burst, clears the detector, drives one-hot
// symbol pulses and reports match hits. Define SEQ_DET_FEED_CNT_EN for hit counters.
module seq_det_feed_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [2*NREQ-1:0] req_sym_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              det_reset_o,
    output logic              det_l_o,
    output logic              det_o_o,
    output logic              det_v_o,
    output logic              det_other_o,
    input  logic              det_volvo_i,
    input  logic              det_vool_i,
    input  logic              det_lol_i,
    input  logic              det_oolvo_i,
    output logic              hit_valid_o,
    output logic [3:0]        hit_mask_o,
    output logic              hit_src_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  cnt_volvo_o,
    output logic [CNT_W-1:0]  cnt_vool_o,
    output logic [CNT_W-1:0]  cnt_lol_o,
    output logic [CNT_W-1:0]  cnt_oolvo_o
);

    feed_state_t state_q, state_d;
    logic        owner_q, owner_d;
    logic [1:0]  sym_q, sym_d;
    logic        last_q, last_d;
    logic        hit_valid_q;
    logic [3:0]  hit_mask_q;
    logic        hit_src_q;

    logic        gnt_valid;
    logic        gnt_src;
    logic        burst_done;
    logic        sample_en;
    logic        cur_valid;
    logic        cur_last;
    logic [1:0]  cur_sym;
    logic [3:0]  flags;

    assign flags = {det_volvo_i, det_vool_i, det_lol_i, det_oolvo_i};

    seq_det_rr_arb u_arb (
        .clock       (clock),
        .reset       (reset),
        .req_i       (req_valid_i[1:0]),
        .done_i      (burst_done),
        .done_src_i  (owner_q),
        .gnt_valid_o (gnt_valid),
        .gnt_src_o   (gnt_src)
    );

    always_comb begin
        cur_valid = req_valid_i[owner_q];
        cur_last  = req_last_i[owner_q];
        cur_sym   = owner_q ? req_sym_i[3:2] : req_sym_i[1:0];
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        sym_d       = sym_q;
        last_d      = last_q;
        burst_done  = 1'b0;
        sample_en   = 1'b0;
        req_ready_o = '0;
        det_reset_o = 1'b0;
        det_l_o     = 1'b0;
        det_o_o     = 1'b0;
        det_v_o     = 1'b0;
        det_other_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    owner_d = gnt_src;
                    state_d = StClr;
                end
            end
            StClr: begin
                det_reset_o = 1'b1;
                state_d     = StFetch;
            end
            StFetch: begin
                // Ownership persists across input gaps; no timeout.
                req_ready_o[owner_q] = 1'b1;
                if (cur_valid) begin
                    sym_d   = cur_sym;
                    last_d  = cur_last;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                {det_other_o, det_v_o, det_o_o, det_l_o} = sym_onehot(sym_q);
                state_d = StSample;
            end
            StSample: begin
                sample_en = 1'b1;
                if (last_q) begin
                    burst_done = 1'b1;
                    state_d    = StIdle;
                end else begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            sym_q   <= SYM_L;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            sym_q   <= sym_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_valid_q <= 1'b0;
            hit_mask_q  <= '0;
            hit_src_q   <= 1'b0;
        end else begin
            hit_valid_q <= sample_en & (|flags);
            if (sample_en) begin
                hit_mask_q <= flags;
                hit_src_q  <= owner_q;
            end
        end
    end

    assign hit_valid_o = hit_valid_q;
    assign hit_mask_o  = hit_mask_q;
    assign hit_src_o   = hit_src_q;
    assign busy_o      = (state_q != StIdle);

`ifdef SEQ_DET_FEED_CNT_EN
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

    // Saturating; only a controller reset clears them, never the per-burst clear.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sample_en && flags[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_volvo_o = cnt_q[HIT_VOLVO];
    assign cnt_vool_o  = cnt_q[HIT_VOOL];
    assign cnt_lol_o   = cnt_q[HIT_LOL];
    assign cnt_oolvo_o = cnt_q[HIT_OOLVO];
`else
    assign cnt_volvo_o = '0;
    assign cnt_vool_o  = '0;
    assign cnt_lol_o   = '0;
    assign cnt_oolvo_o = '0;
`endif

endmodule
